// File: rtl/dm_bus_pkg.sv
// Shared types and constants for the data-memory to SoC bus bridge.
package dm_bus_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StWaitRsp = 2'd2,
    StDone    = 2'd3
  } state_e;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ALIGN    = 3'd1;
  localparam logic [2:0] ERR_CONFLICT = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
  localparam logic [2:0] ERR_SLAVE    = 3'd4;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } bus_req_t;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Saturating cycle counter; expired marks the last allowed cycle of a bus access.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dm_bus_bridge.sv
// Turns a single-cycle CPU load/store into one valid/ready bus transaction,
// stalling the CPU until the response (or an error) resolves the access.
module dm_bus_bridge
  import dm_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_r_mem,
  input  logic              cpu_w_mem,
  input  logic [DATA_W-1:0] cpu_w_data,
  output logic [DATA_W-1:0] cpu_r_data,
  output logic              cpu_stall,
  output logic              cpu_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_we,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rsp_data,
  input  logic              bus_rsp_err,
  output logic              err_flag
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        err_code_q, err_code_d;
  logic              err_flag_q, err_flag_d;
  logic              access;
  logic              expired;

  assign access = cpu_r_mem | cpu_w_mem;

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == StIdle),
    .enable  ((state_q == StReq) || (state_q == StWaitRsp)),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_code_d = err_code_q;
    err_flag_d = err_flag_q;

    unique case (state_q)
      StIdle: begin
        if (access) begin
          rdata_d = '0;
          state_d = StDone;
          if (cpu_r_mem && cpu_w_mem) begin
            err_code_d = ERR_CONFLICT;
          end else if (!is_word_aligned(cpu_addr[1:0])) begin
            err_code_d = ERR_ALIGN;
          end else begin
            addr_d     = cpu_addr;
            we_d       = cpu_w_mem;
            wdata_d    = cpu_w_data;
            err_code_d = ERR_NONE;
            state_d    = StReq;
          end
        end
      end
      StReq: begin
        // A response strobe here is not legal and is ignored.
        if (bus_req_ready) begin
          state_d = StWaitRsp;
        end else if (expired) begin
          rdata_d    = '0;
          err_code_d = ERR_TIMEOUT;
          state_d    = StDone;
        end
      end
      StWaitRsp: begin
        if (bus_rsp_valid) begin
          rdata_d    = we_q ? '0 : bus_rsp_data;
          err_code_d = bus_rsp_err ? ERR_SLAVE : ERR_NONE;
          state_d    = StDone;
        end else if (expired) begin
          rdata_d    = '0;
          err_code_d = ERR_TIMEOUT;
          state_d    = StDone;
        end
      end
      StDone: begin
        err_flag_d = err_flag_q | (err_code_q != ERR_NONE);
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_code_q <= ERR_NONE;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_code_q <= err_code_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign cpu_stall     = access & (state_q != StDone);
  assign cpu_r_data    = (state_q == StDone) ? rdata_q : '0;
  assign cpu_err       = (state_q == StDone) && (err_code_q != ERR_NONE);
  assign bus_req_valid = (state_q == StReq);
  assign bus_req_we    = we_q;
  assign bus_req_addr  = addr_q;
  assign bus_req_wdata = wdata_q;
  assign err_flag      = err_flag_q;

endmodule

// File: tb/tb_dm_bus_bridge.sv
// Directed bench for dm_bus_bridge: loads, stores, alignment/conflict errors,
// timeouts, slave errors and reset in the middle of a transaction.
module tb_dm_bus_bridge;
  import dm_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        cpu_r_mem;
  logic        cpu_w_mem;
  logic [31:0] cpu_w_data;
  logic [31:0] cpu_r_data;
  logic        cpu_stall;
  logic        cpu_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_we;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_data;
  logic        bus_rsp_err;
  logic        err_flag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dm_bus_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_addr      (cpu_addr),
    .cpu_r_mem     (cpu_r_mem),
    .cpu_w_mem     (cpu_w_mem),
    .cpu_w_data    (cpu_w_data),
    .cpu_r_data    (cpu_r_data),
    .cpu_stall     (cpu_stall),
    .cpu_err       (cpu_err),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_we    (bus_req_we),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wdata (bus_req_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_data  (bus_rsp_data),
    .bus_rsp_err   (bus_rsp_err),
    .err_flag      (err_flag)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Holds the CPU request until DONE; the slave raises ready on valid-cycle
  // rdy_dly and responds on wait-cycle rsp_dly (negative = never).
  task automatic run_access(
    input  logic        r,
    input  logic        w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  int          rdy_dly,
    input  int          rsp_dly,
    input  logic [31:0] rsp_data,
    input  logic        rsp_err,
    input  logic        spurious,
    output int          stall_cyc,
    output int          valid_cyc,
    output bus_req_t    req,
    output logic        stable,
    output logic [31:0] rdata,
    output logic        err,
    output logic        done
  );
    logic handshaken;
    logic hs_now;
    int   wait_idx;
    stall_cyc  = 0;
    valid_cyc  = 0;
    req        = '0;
    stable     = 1'b1;
    rdata      = '0;
    err        = 1'b0;
    done       = 1'b0;
    handshaken = 1'b0;
    wait_idx   = 0;
    cpu_r_mem  = r;
    cpu_w_mem  = w;
    cpu_addr   = addr;
    cpu_w_data = wdata;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      bus_rsp_err   = 1'b0;
      bus_rsp_data  = '0;
      #1;
      if (!cpu_stall) begin
        done  = 1'b1;
        rdata = cpu_r_data;
        err   = cpu_err;
      end else begin
        stall_cyc++;
        if (bus_req_valid) begin
          if (valid_cyc == 0) begin
            req = '{we: bus_req_we, addr: bus_req_addr, wdata: bus_req_wdata};
          end else if (req != {bus_req_we, bus_req_addr, bus_req_wdata}) begin
            stable = 1'b0;
          end
          if (valid_cyc == rdy_dly) bus_req_ready = 1'b1;
          if (spurious) begin
            bus_rsp_valid = 1'b1;
            bus_rsp_err   = 1'b1;
            bus_rsp_data  = 32'hFFFF_FFFF;
          end
          valid_cyc++;
        end else if (handshaken) begin
          if (wait_idx == rsp_dly) begin
            bus_rsp_valid = 1'b1;
            bus_rsp_data  = rsp_data;
            bus_rsp_err   = rsp_err;
          end
          wait_idx++;
        end
      end
      hs_now = bus_req_ready;
      @(negedge clk);
      if (hs_now) handshaken = 1'b1;
    end
    cpu_r_mem     = 1'b0;
    cpu_w_mem     = 1'b0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
    bus_rsp_data  = '0;
  endtask

  int          stall_cyc, valid_cyc;
  bus_req_t    req;
  logic        stable, err, done;
  logic [31:0] rdata;

  initial begin
    rst           = 1'b1;
    cpu_addr      = '0;
    cpu_r_mem     = 1'b0;
    cpu_w_mem     = 1'b0;
    cpu_w_data    = '0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_data  = '0;
    bus_rsp_err   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_valid", 32'(bus_req_valid), 32'd0);
    check_eq("rst_stall", 32'(cpu_stall), 32'd0);
    check_eq("rst_err", 32'(cpu_err), 32'd0);
    check_eq("rst_flag", 32'(err_flag), 32'd0);
    check_eq("rst_rdata", cpu_r_data, 32'd0);
    check_eq("rst_addr", bus_req_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Aligned load, immediate ready and response.
    run_access(1, 0, 32'h10, 32'h0, 0, 0, 32'h1234_5678, 0, 0,
               stall_cyc, valid_cyc, req, stable, rdata, err, done);
    check_eq("ld_done", 32'(done), 32'd1);
    check_eq("ld_stall", 32'(stall_cyc), 32'd3);
    check_eq("ld_valid", 32'(valid_cyc), 32'd1);
    check_eq("ld_addr", req.addr, 32'h10);
    check_eq("ld_we", 32'(req.we), 32'd0);
    check_eq("ld_rdata", rdata, 32'h1234_5678);
    check_eq("ld_err", 32'(err), 32'd0);
    #1;
    check_eq("ld_rdata_idle", cpu_r_data, 32'd0);

    // Store, ready late, response late, illegal rsp strobes during REQ.
    run_access(0, 1, 32'h20, 32'hCAFE_F00D, 4, 1, 32'h0, 0, 1,
               stall_cyc, valid_cyc, req, stable, rdata, err, done);
    check_eq("st_stall", 32'(stall_cyc), 32'd8);
    check_eq("st_valid", 32'(valid_cyc), 32'd5);
    check_eq("st_stable", 32'(stable), 32'd1);
    check_eq("st_we", 32'(req.we), 32'd1);
    check_eq("st_wdata", req.wdata, 32'hCAFE_F00D);
    check_eq("st_rdata", rdata, 32'd0);
    check_eq("st_err", 32'(err), 32'd0);
    check_eq("st_flag", 32'(err_flag), 32'd0);

    // Ready never comes: abort after TIMEOUT cycles in REQ.
    run_access(1, 0, 32'h24, 32'h0, -1, 0, 32'h0, 0, 0,
               stall_cyc, valid_cyc, req, stable, rdata, err, done);
    check_eq("to_req_done", 32'(done), 32'd1);
    check_eq("to_req_valid", 32'(valid_cyc), 32'd8);
    check_eq("to_req_stall", 32'(stall_cyc), 32'd9);
    check_eq("to_req_err", 32'(err), 32'd1);
    check_eq("to_req_rdata", rdata, 32'd0);
    check_eq("to_req_flag", 32'(err_flag), 32'd1);
    #1;
    check_eq("to_req_valid_low", 32'(bus_req_valid), 32'd0);

    // Following access proceeds normally.
    run_access(1, 0, 32'h30, 32'h0, 0, 0, 32'hA5A5_0001, 0, 0,
               stall_cyc, valid_cyc, req, stable, rdata, err, done);
    check_eq("after_to_stall", 32'(stall_cyc), 32'd3);
    check_eq("after_to_rdata", rdata, 32'hA5A5_0001);
    check_eq("after_to_err", 32'(err), 32'd0);

    // Response never comes: abort in WAIT_RSP.
    run_access(1, 0, 32'h34, 32'h0, 0, -1, 32'h0, 0, 0,
               stall_cyc, valid_cyc, req, stable, rdata, err, done);
    check_eq("to_rsp_stall", 32'(stall_cyc), 32'd9);
    check_eq("to_rsp_valid", 32'(valid_cyc), 32'd1);
    check_eq("to_rsp_err", 32'(err), 32'd1);
    check_eq("to_rsp_rdata", rdata, 32'd0);

    // Slave error response.
    run_access(1, 0, 32'h38, 32'h0, 1, 0, 32'h0, 1, 0,
               stall_cyc, valid_cyc, req, stable, rdata, err, done);
    check_eq("slv_stall", 32'(stall_cyc), 32'd4);
    check_eq("slv_err", 32'(err), 32'd1);

    // Misaligned load: no bus activity.
    run_access(1, 0, 32'h13, 32'h0, 0, 0, 32'h0, 0, 0,
               stall_cyc, valid_cyc, req, stable, rdata, err, done);
    check_eq("mis_stall", 32'(stall_cyc), 32'd1);
    check_eq("mis_valid", 32'(valid_cyc), 32'd0);
    check_eq("mis_err", 32'(err), 32'd1);
    check_eq("mis_rdata", rdata, 32'd0);

    // Read and write together: no bus activity.
    run_access(1, 1, 32'h40, 32'h5555_AAAA, 0, 0, 32'h0, 0, 0,
               stall_cyc, valid_cyc, req, stable, rdata, err, done);
    check_eq("cfl_stall", 32'(stall_cyc), 32'd1);
    check_eq("cfl_valid", 32'(valid_cyc), 32'd0);
    check_eq("cfl_err", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check_eq("flag_sticky", 32'(err_flag), 32'd1);
    check_eq("idle_err", 32'(cpu_err), 32'd0);

    // Reset in WAIT_RSP, then a late response.
    @(negedge clk);
    cpu_r_mem = 1'b1;
    cpu_addr  = 32'h50;
    @(negedge clk);
    #1;
    check_eq("rstmid_req", 32'(bus_req_valid), 32'd1);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    cpu_r_mem     = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = 32'hDEAD_BEEF;
    bus_rsp_err   = 1'b1;
    #1;
    check_eq("rstmid_valid", 32'(bus_req_valid), 32'd0);
    check_eq("rstmid_stall", 32'(cpu_stall), 32'd0);
    check_eq("rstmid_addr", bus_req_addr, 32'd0);
    check_eq("rstmid_flag", 32'(err_flag), 32'd0);
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
    bus_rsp_data  = '0;
    #1;
    check_eq("late_rsp_err", 32'(cpu_err), 32'd0);
    check_eq("late_rsp_rdata", cpu_r_data, 32'd0);
    check_eq("late_rsp_flag", 32'(err_flag), 32'd0);
    @(negedge clk);

    // Normal store after reset.
    run_access(0, 1, 32'h44, 32'h0BAD_F00D, 0, 0, 32'h0, 0, 0,
               stall_cyc, valid_cyc, req, stable, rdata, err, done);
    check_eq("post_rst_stall", 32'(stall_cyc), 32'd3);
    check_eq("post_rst_addr", req.addr, 32'h44);
    check_eq("post_rst_err", 32'(err), 32'd0);
    check_eq("post_rst_flag", 32'(err_flag), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dm_bus_bridge.md
Name: dm_bus_bridge

Overview:
- Sits directly downstream of the single-cycle CPU's data-memory port and replaces the ideal zero-wait DM.
- Converts a CPU load or store (addr, MemRead, MemWrite, write data) into one transaction on the SoC valid/ready bus.
- Stalls the CPU until the response returns, then presents the read data.
- Flags misaligned, conflicting and timed-out accesses.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT_RSP before the access is aborted.

Ports:
- clk  in  1  system clock; one clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- cpu_addr  in  ADDR_W  byte address (ALU result).
- cpu_r_mem  in  1  load request (MemRead).
- cpu_w_mem  in  1  store request (MemWrite).
- cpu_w_data  in  DATA_W  store data (rt register value).
- cpu_r_data  out  DATA_W  load data; valid only in DONE.
- cpu_stall  out  1  freezes the PC and the register-file write while high.
- cpu_err  out  1  one-cycle pulse in DONE when the access failed.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  request accepted.
- bus_req_we  out  1  1 = write, 0 = read.
- bus_req_addr  out  ADDR_W  word-aligned request address.
- bus_req_wdata  out  DATA_W  write data.
- bus_rsp_valid  in  1  response strobe; required for both reads and writes.
- bus_rsp_data  in  DATA_W  read response data.
- bus_rsp_err  in  1  slave error, qualified by bus_rsp_valid.
- err_flag  out  1  sticky error indicator, cleared only by rst.

Behaviour:
- States: IDLE, REQ, WAIT_RSP, DONE.
- Reset values: state=IDLE; all outputs 0; latched addr/wdata/rdata = 0; timeout counter = 0.
- cpu_stall is combinational: (cpu_r_mem | cpu_w_mem) & (state != DONE). It is 0 when there is no access.
- IDLE, access present:
  - If cpu_r_mem & cpu_w_mem, or cpu_addr[1:0] != 0: go to DONE with the error flag set and rdata=0. No bus transaction is issued.
  - Otherwise latch addr, we=cpu_w_mem and wdata, then go to REQ.
- REQ:
  - bus_req_valid=1; addr, we and wdata are held stable until the handshake.
  - On bus_req_ready go to WAIT_RSP. Valid drops the following cycle.
  - Back-to-back requests are impossible because DONE always intervenes.
- WAIT_RSP:
  - On bus_rsp_valid, capture bus_rsp_data (reads only) and bus_rsp_err, then go to DONE.
  - bus_rsp_valid in the same cycle as the ready handshake is not legal. It is ignored by REQ; the bridge waits in WAIT_RSP.
- Timeout:
  - The counter clears on leaving IDLE and increments each cycle in REQ/WAIT_RSP.
  - When count == TIMEOUT-1 and the transaction is not completing that cycle: go to DONE with error, rdata=0, bus_req_valid deasserted.
  - An abort in REQ is the only allowed valid-without-ready drop.
- DONE (exactly 1 cycle):
  - cpu_stall=0 and cpu_r_data=latched rdata.
  - cpu_err=error, and err_flag is set if error.
  - Next state is IDLE. The CPU advances at this edge.
- Latency: an aligned access with ready and response both immediate takes IDLE→REQ→WAIT_RSP→DONE. That is 3 stall cycles plus the DONE cycle.
- Stores: cpu_r_data=0 in DONE.
- Spurious bus_rsp_valid in IDLE, REQ or DONE is ignored and does not set an error.
- Access withdrawn (r_mem=w_mem=0) after IDLE: the transaction still completes on the bus, with no side effect on the CPU.
- rst mid-transaction:
  - Immediate return to IDLE; bus_req_valid drops at the reset edge.
  - The bus fabric is reset concurrently, so no protocol violation reaches a live slave.

Decomposition:
- Shared package dm_bus_pkg holds:
  - the state enum (IDLE=2'd0, REQ=2'd1, WAIT_RSP=2'd2, DONE=2'd3);
  - the ADDR_W/DATA_W defaults;
  - the error-code constants (ERR_NONE, ERR_ALIGN, ERR_CONFLICT, ERR_TIMEOUT, ERR_SLAVE);
  - the shared bus request struct.
- One sub-module, bus_timeout_ctr:
  - parameter TIMEOUT;
  - inputs clk, rst, clear, enable;
  - output expired.

Test Plan:
- Load from 0x0000_0010, ready and rsp immediate, rsp_data=0x1234_5678 → stall high 3 cycles; DONE shows cpu_r_data=0x1234_5678; cpu_err=0; bus_req_addr=0x10, we=0.
- Store 0xCAFE_F00D to 0x20, ready delayed 4 cycles, rsp after 2 more → valid/addr/wdata stable throughout REQ; stall 8 cycles; cpu_r_data=0 in DONE.
- Load from 0x0000_0013 → no bus_req_valid ever; DONE next cycle; cpu_err pulse; err_flag stays 1 until rst.
- cpu_r_mem=cpu_w_mem=1 at 0x40 → same as misaligned: no bus activity, error.
- TIMEOUT=8, ready never asserted → bus_req_valid high 8 cycles then drops; DONE with cpu_err=1, rdata=0; next access proceeds normally.
- rst asserted in WAIT_RSP, late rsp_valid arrives after reset → state IDLE, all outputs 0, late response ignored, err_flag=0.
